// File: rtl/mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter
//
// Shares a single variable-latency memory port between the instruction
// fetch stage (read-only) and the MEM-stage data access (read/write).
// One requester is granted at a time. The granted access is driven onto
// the memory port with a req/ack handshake. The read data for each
// requester is returned in its own register. A pipeline-wide stall is
// raised while any request is still waiting for its ready pulse.
//
// Arbitration: data wins by default. After MAX_CONSEC data grants made
// while fetch was also waiting, fetch is forced in, so it cannot starve.
//
// A BUSY access that receives no ack within TIMEOUT cycles is aborted.
// The requester still gets its ready pulse, its read data is left
// unchanged, and the sticky err_o flag is set.
//
// Ports
//   clk_i, rst_i         clock, asynchronous active-high reset
//   if_req_i/if_addr_i   fetch request and address (held until ready)
//   if_ready_o           one-cycle fetch completion pulse
//   if_rdata_o           last fetched word
//   dm_req_i/dm_we_i     data request and write enable
//   dm_addr_i/dm_wdata_i data address and write data
//   dm_ready_o           one-cycle data completion pulse
//   dm_rdata_o           last loaded word
//   mem_req_o/mem_we_o   memory request and write enable
//   mem_addr_o           memory address, stable during the access
//   mem_wdata_o          memory write data, stable during the access
//   mem_ack_i            single-cycle memory completion
//   mem_rdata_i          memory read data, valid with mem_ack_i
//   stall_o              pipeline stall (all_stall)
//   err_o                sticky timeout flag
// ---------------------------------------------------------------------------
module mem_port_arbiter #(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned MAX_CONSEC = 4,    // 1..15
  parameter int unsigned TIMEOUT    = 255   // 1..255
) (
  input  logic              clk_i,
  input  logic              rst_i,
  // instruction fetch requester
  input  logic              if_req_i,
  input  logic [ADDR_W-1:0] if_addr_i,
  output logic              if_ready_o,
  output logic [DATA_W-1:0] if_rdata_o,
  // data requester
  input  logic              dm_req_i,
  input  logic              dm_we_i,
  input  logic [ADDR_W-1:0] dm_addr_i,
  input  logic [DATA_W-1:0] dm_wdata_i,
  output logic              dm_ready_o,
  output logic [DATA_W-1:0] dm_rdata_o,
  // memory port
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic              mem_ack_i,
  input  logic [DATA_W-1:0] mem_rdata_i,
  // status
  output logic              stall_o,
  output logic              err_o
);

  localparam int unsigned CW = 4;  // holds MAX_CONSEC up to 15
  localparam int unsigned TW = 8;  // holds TIMEOUT up to 255

  localparam logic [CW-1:0] CONSEC_MAX = CW'(MAX_CONSEC);
  // tcnt starts at 0 in the first BUSY cycle, so the last allowed cycle
  // is TIMEOUT-1. This gives exactly TIMEOUT cycles of mem_req_o.
  localparam logic [TW-1:0] TCNT_LAST  = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  // registered grant and access
  logic              r_grant_if;   // 1 = fetch owns the current access
  logic              r_mem_we;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [DATA_W-1:0] r_mem_wdata;

  // returned read data
  logic [DATA_W-1:0] r_if_rdata;
  logic [DATA_W-1:0] r_dm_rdata;

  // fairness and timeout bookkeeping
  logic [CW-1:0]     r_consec;
  logic [TW-1:0]     r_tcnt;
  logic              r_err;

  // combinational decode
  logic w_any_req;
  logic w_grant_if;
  logic w_start;
  logic w_ack;
  logic w_timeout;

  assign w_any_req = if_req_i | dm_req_i;

  // Fetch wins when it is alone, or when data has had its maximum run of
  // grants against a waiting fetch.
  assign w_grant_if = if_req_i & (~dm_req_i | (r_consec == CONSEC_MAX));

  assign w_start   = (r_state == S_IDLE) & w_any_req;

  // The ack only counts in BUSY. Stray acks in IDLE/DONE are ignored.
  assign w_ack     = (r_state == S_BUSY) & mem_ack_i;
  assign w_timeout = (r_state == S_BUSY) & ~mem_ack_i & (r_tcnt == TCNT_LAST);

  // -------------------------------------------------------------------------
  // State register
  // -------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking (<=) so every flop samples
  // pre-edge values. Blocking here would create order-dependent races.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  // NOTE: the default assignment ahead of the case is what keeps this block
  // purely combinational. A path that leaves w_state_nxt unassigned would
  // infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE: if (w_any_req)           w_state_nxt = S_BUSY;
      S_BUSY: if (w_ack || w_timeout)  w_state_nxt = S_DONE;
      S_DONE:                          w_state_nxt = S_IDLE;
      default:                         w_state_nxt = S_IDLE;
    endcase
  end

  // -------------------------------------------------------------------------
  // Grant and access registers: loaded once in IDLE and held through BUSY,
  // so the memory sees a stable address/data for the whole access.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_grant_if  <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
    end else if (w_start) begin
      r_grant_if <= w_grant_if;
      if (w_grant_if) begin
        r_mem_we    <= 1'b0;
        r_mem_addr  <= if_addr_i;
        r_mem_wdata <= '0;
      end else begin
        r_mem_we    <= dm_we_i;
        r_mem_addr  <= dm_addr_i;
        r_mem_wdata <= dm_wdata_i;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Consecutive-data-grant counter. It only counts data grants that beat a
  // waiting fetch. Any fetch grant, or an uncontended data grant, restarts
  // the count.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_consec <= '0;
    end else if (w_start) begin
      if (w_grant_if || !if_req_i) begin
        r_consec <= '0;
      end else if (r_consec != CONSEC_MAX) begin
        r_consec <= r_consec + 1'b1;
      end
    end
  end

  // -------------------------------------------------------------------------
  // BUSY cycle counter and sticky error flag
  // -------------------------------------------------------------------------
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_tcnt <= '0;
      r_err  <= 1'b0;
    end else begin
      if (w_start) begin
        r_tcnt <= '0;
      end else if (r_state == S_BUSY && !w_ack && !w_timeout) begin
        r_tcnt <= r_tcnt + 1'b1;
      end
      if (w_timeout) begin
        r_err <= 1'b1;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Read data capture. Writes and timeouts leave the registers unchanged.
  // -------------------------------------------------------------------------
  // NOTE: these are plain data registers, not a memory array, so they are
  // reset. The reset value of 0 is visible on if_rdata_o/dm_rdata_o.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_if_rdata <= '0;
      r_dm_rdata <= '0;
    end else if (w_ack) begin
      if (r_grant_if) begin
        r_if_rdata <= mem_rdata_i;
      end else if (!r_mem_we) begin
        r_dm_rdata <= mem_rdata_i;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  // mem_req_o is decoded from the async-reset state, so it drops as soon
  // as rst_i rises.
  assign mem_req_o   = (r_state == S_BUSY);
  assign mem_we_o    = r_mem_we;
  assign mem_addr_o  = r_mem_addr;
  assign mem_wdata_o = r_mem_wdata;

  assign if_ready_o  = (r_state == S_DONE) &  r_grant_if;
  assign dm_ready_o  = (r_state == S_DONE) & ~r_grant_if;

  assign if_rdata_o  = r_if_rdata;
  assign dm_rdata_o  = r_dm_rdata;
  assign err_o       = r_err;

  // A requester stops stalling the pipe in its own ready cycle. The stall
  // holds only if the other side is still waiting. The requests are held
  // inputs, so the stall is forced low during reset.
  assign stall_o = ~rst_i & ((if_req_i & ~if_ready_o) | (dm_req_i & ~dm_ready_o));

endmodule
